pcl_prefetch_unit: RTL and testbench

//  Parametrised fetch front end: PC generator, in-order instruction-memory request port and DEPTH-entry prefetch queue.

---
 rtl/pcl_fetch_pkg.sv | 31 +++
 rtl/pcl_fetch_queue.sv | 75 +++++++
 rtl/pcl_prefetch_unit.sv | 111 +++++++++++
 tb/tb_pcl_prefetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pcl_fetch_pkg.sv
// Shared types and width helpers for the prefetch unit and its queue.
// The optional response bypass is enabled by defining PCL_FETCH_BYPASS_EN.
package pcl_fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_INST_W = 32;

  // One queue slot at the default widths (the queue stores the fields in separate arrays).
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
    logic                    filled;
  } fetch_entry_t;

  function automatic int pc_step(input int inst_w);
    return inst_w / 8;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int drop_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pcl_fetch_queue.sv
// Circular prefetch buffer: entries are allocated in request order, filled in
// response order and popped in order; head..fill are filled, fill..tail are pending.
module pcl_fetch_queue
  import pcl_fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop,
  output logic              head_filled,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic              full,
  output logic [CNT_W-1:0]  unfilled_cnt
);

  logic [PTR_W-1:0]  head_reg, tail_reg, fill_reg;
  logic [CNT_W-1:0]  alloc_cnt_reg, unfilled_cnt_reg;
  logic [CNT_W-1:0]  alloc_cnt_next, unfilled_cnt_next;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic do_alloc, do_fill, do_pop, head_waiting, pop_unfilled;

  assign full         = (alloc_cnt_reg == CNT_W'(DEPTH));
  assign head_filled  = (alloc_cnt_reg != unfilled_cnt_reg);
  assign head_waiting = ~head_filled & (unfilled_cnt_reg != '0);
  assign unfilled_cnt = unfilled_cnt_reg;

  assign do_alloc = alloc & ~flush & ~full;
  assign do_fill  = fill & ~flush & (unfilled_cnt_reg != '0);
  // A pop of a still-pending head is only legal when its data arrives this cycle.
  assign do_pop       = pop & ~flush & (head_filled | (head_waiting & do_fill));
  assign pop_unfilled = do_pop & ~head_filled;

  assign head_pc   = pc_mem[head_reg];
  assign head_inst = inst_mem[head_reg];

  always_comb begin
    alloc_cnt_next    = alloc_cnt_reg + CNT_W'(do_alloc) - CNT_W'(do_pop);
    unfilled_cnt_next = unfilled_cnt_reg + CNT_W'(do_alloc) - CNT_W'(do_fill);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      fill_reg         <= '0;
      alloc_cnt_reg    <= '0;
      unfilled_cnt_reg <= '0;
    end else begin
      if (do_alloc) tail_reg <= tail_reg + PTR_W'(1);
      if (do_fill)  fill_reg <= fill_reg + PTR_W'(1);
      if (do_pop)   head_reg <= head_reg + PTR_W'(1);
      alloc_cnt_reg    <= alloc_cnt_next;
      unfilled_cnt_reg <= unfilled_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) pc_mem[tail_reg] <= alloc_pc;
    if (do_fill && !pop_unfilled) inst_mem[fill_reg] <= fill_inst;
  end

endmodule

// File: rtl/pcl_prefetch_unit.sv
// Fetch front end: PC generator, in-order memory request port and prefetch queue
// with redirect flush and stale-response dropping. Define PCL_FETCH_BYPASS_EN for
// same-cycle response-to-decode forwarding.
module pcl_prefetch_unit
  import pcl_fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              INST_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int              DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iRedirEn,
  input  logic [ADDR_W-1:0] iRedirPc,
  output logic              oReqVld,
  output logic [ADDR_W-1:0] oReqAddr,
  input  logic              iReqRdy,
  input  logic              iRspVld,
  input  logic [INST_W-1:0] iRspInst,
  output logic              oInstVld,
  output logic [INST_W-1:0] oInst,
  output logic [ADDR_W-1:0] oInstPc,
  input  logic              iInstRdy
);

  localparam int PC_STEP = pc_step(INST_W);
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int DROP_W  = drop_width(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

  logic [ADDR_W-1:0] req_pc_reg;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [DROP_W:0]   drop_sum;

  logic              q_head_filled, q_full;
  logic [ADDR_W-1:0] q_head_pc;
  logic [INST_W-1:0] q_head_inst;
  logic [CNT_W-1:0]  q_unfilled_cnt;

  logic req_fire, rsp_drop, rsp_take, bypass, pop;

  assign oReqVld  = ~rst & ~iRedirEn & ~q_full;
  assign oReqAddr = req_pc_reg;
  assign req_fire = oReqVld & iReqRdy;

  assign rsp_drop = iRspVld & (drop_cnt_reg != '0);
  assign rsp_take = iRspVld & (drop_cnt_reg == '0) & ~iRedirEn;

`ifdef PCL_FETCH_BYPASS_EN
  // Head is pending and this response is its data: forward it straight to decode.
  assign bypass = rsp_take & ~q_head_filled & (q_unfilled_cnt != '0);
`else
  assign bypass = 1'b0;
`endif

  assign oInstVld = q_head_filled | bypass;
  assign oInst    = q_head_filled ? q_head_inst : (bypass ? iRspInst : '0);
  assign oInstPc  = oInstVld ? q_head_pc : '0;
  assign pop      = oInstVld & iInstRdy & ~iRedirEn;

  // Responses still in flight for flushed entries must be discarded when they return.
  always_comb begin
    drop_sum      = (DROP_W+1)'(q_unfilled_cnt) + {1'b0, drop_cnt_reg};
    drop_cnt_next = drop_cnt_reg;
    if (iRedirEn) begin
      if (!iRspVld)
        drop_cnt_next = DROP_W'(drop_sum);
      else if (drop_sum != '0)
        drop_cnt_next = DROP_W'(drop_sum - (DROP_W+1)'(1));
      else
        drop_cnt_next = '0;
    end else if (rsp_drop) begin
      drop_cnt_next = drop_cnt_reg - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_reg   <= START_ADDR;
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
      if (iRedirEn)
        req_pc_reg <= iRedirPc & ALIGN_MASK;
      else if (req_fire)
        req_pc_reg <= req_pc_reg + ADDR_W'(PC_STEP);
    end
  end

  pcl_fetch_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush        (iRedirEn),
    .alloc        (req_fire),
    .alloc_pc     (req_pc_reg),
    .fill         (rsp_take),
    .fill_inst    (iRspInst),
    .pop          (pop),
    .head_filled  (q_head_filled),
    .head_pc      (q_head_pc),
    .head_inst    (q_head_inst),
    .full         (q_full),
    .unfilled_cnt (q_unfilled_cnt)
  );

endmodule

// File: tb/tb_pcl_prefetch_unit.sv
// Randomized scoreboard bench for pcl_prefetch_unit with an in-order variable-latency
// memory model; stale responses are identified by redirect epoch. Honors PCL_FETCH_BYPASS_EN.
module tb_pcl_prefetch_unit;
  import pcl_fetch_pkg::*;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int N_CYC  = 4000;
  localparam logic [31:0] START = 32'hFFFF_FFF0;
`ifdef PCL_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redir_en, req_vld, req_rdy, rsp_vld, inst_vld, inst_rdy;
  logic [31:0] redir_pc, req_addr, rsp_inst, inst, inst_pc;

  pcl_prefetch_unit #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .START_ADDR(START), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .iRedirEn(redir_en), .iRedirPc(redir_pc),
    .oReqVld(req_vld), .oReqAddr(req_addr), .iReqRdy(req_rdy),
    .iRspVld(rsp_vld), .iRspInst(rsp_inst),
    .oInstVld(inst_vld), .oInst(inst), .oInstPc(inst_pc), .iInstRdy(inst_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { fetch_entry_t e; int fill_cyc; } sb_item_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;

  sb_item_t sb[$];
  pend_t    pend[$];
  int total = 0, bad = 0, xfer_cnt = 0;
  int epoch = 0, rsp_epoch = 0, last_due = 0;
  logic [31:0] model_pc = START;
  bit prev_rst = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Stimulus and memory: drives inputs just after each rising edge.
  initial begin
    redir_en = 0; redir_pc = 0; req_rdy = 0; rsp_vld = 0; rsp_inst = 0; inst_rdy = 0;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk); #1;
      rst = (c < 3) || (c >= 2000 && c < 2002);
      redir_en = !rst && !(c >= 100 && c < 300) && ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       redir_pc = 32'h0000_0103;
        1:       redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redir_pc = $urandom();
      endcase
      req_rdy  = (c >= 100 && c < 300) ? 1'b1 : ($urandom_range(0, 4) != 0);
      inst_rdy = (c >= 400 && c < 440) ? 1'b0 :
                 (c >= 100 && c < 300) ? 1'b1 : ($urandom_range(0, 4) != 0);
      rsp_vld  = 1'b0;
      rsp_inst = '0;
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
        rsp_vld   = 1'b1;
        rsp_inst  = mem_word(pend[0].addr);
        rsp_epoch = pend[0].epoch;
        void'(pend.pop_front());
      end
    end
    @(posedge clk); #1;
    chk("progress", 64'(xfer_cnt >= 300), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Request side: checks request port, records issued fetches, tracks responses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("req_vld_rst", 64'(req_vld), 64'd0);
        if (prev_rst) begin
          chk("req_addr_rst", 64'(req_addr), 64'(START));
          chk("inst_vld_rst", 64'(inst_vld), 64'd0);
          chk("inst_rst", 64'(inst), 64'd0);
          chk("inst_pc_rst", 64'(inst_pc), 64'd0);
        end
        sb.delete();
        pend.delete();
        model_pc = START;
        last_due = cyc;
        epoch++;
      end else if (redir_en) begin
        chk("req_vld_redir", 64'(req_vld), 64'd0);
        model_pc = redir_pc & ~32'h3;
        epoch++;
        sb.delete();
      end else begin
        chk("req_vld", 64'(req_vld), 64'(sb.size() < DEPTH));
        if (rsp_vld && rsp_epoch == epoch) begin
          for (int i = 0; i < sb.size(); i++) begin
            if (!sb[i].e.filled) begin
              sb[i].e.filled = 1'b1;
              sb[i].fill_cyc = cyc;
              break;
            end
          end
        end
        if (req_vld && req_rdy) begin
          int due;
          sb_item_t it;
          chk("req_addr", 64'(req_addr), 64'(model_pc));
          due = cyc + $urandom_range(1, 3);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{addr: req_addr, epoch: epoch, due: due});
          it.e.pc     = model_pc;
          it.e.inst   = mem_word(model_pc);
          it.e.filled = 1'b0;
          it.fill_cyc = -1;
          sb.push_back(it);
          $display("req  cyc=%0d addr=%h", cyc, req_addr);
          model_pc = model_pc + 32'd4;
        end
      end
      prev_rst = rst;
    end
  end

  // Decode-side monitor: pops the scoreboard whenever an instruction is handed off.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst && !redir_en) begin
        bit exp_vld;
        exp_vld = 1'b0;
        if (sb.size() > 0 && sb[0].e.filled)
          exp_vld = BYP ? (sb[0].fill_cyc <= cyc) : (sb[0].fill_cyc < cyc);
        chk("inst_vld", 64'(inst_vld), 64'(exp_vld));
        if (inst_vld && inst_rdy) begin
          if (sb.size() == 0) begin
            chk("inst_unexpected", 64'd1, 64'd0);
          end else begin
            chk("inst_pc", 64'(inst_pc), 64'(sb[0].e.pc));
            chk("inst_data", 64'(inst), 64'(sb[0].e.inst));
            $display("dec  cyc=%0d pc=%h inst=%h", cyc, inst_pc, inst);
            void'(sb.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

endmodule
